// File: rtl/lsu_if.sv
// Bus bundle for the load/store stage: e2l input handshake, data-memory port, l2w output handshake.
// The access-size and writeback-source encodings shared with execute live here too.
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S 4'd0
`endif
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U 4'd1
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S 4'd2
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U 4'd3
`endif
`ifndef RAM_BYT_4_U
`define RAM_BYT_4_U 4'd4
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 4'd1
`endif

interface lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARGS_WIDTH = 4,
    parameter int GPRS_WIDTH = 5
);
    logic                  i_e2l_valid;
    logic                  o_lsu_ready;
    logic [ADDR_WIDTH-1:0] i_e2l_pc;
    logic                  i_e2l_ctr_reg_wr_en;
    logic [ARGS_WIDTH-1:0] i_e2l_ctr_reg_wr_src;
    logic [GPRS_WIDTH-1:0] i_e2l_gpr_rd_id;
    logic [ARGS_WIDTH-1:0] i_e2l_ctr_ram_byt;
    logic                  i_e2l_ctr_ram_wr_en;
    logic [DATA_WIDTH-1:0] i_e2l_res;
    logic [DATA_WIDTH-1:0] i_e2l_rs2_data;

    logic                  o_ram_req;
    logic                  o_ram_wr_en;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [3:0]            o_ram_wstrb;
    logic [DATA_WIDTH-1:0] o_ram_wdata;
    logic                  i_ram_gnt;
    logic                  i_ram_rvalid;
    logic [DATA_WIDTH-1:0] i_ram_rdata;

    logic                  o_lsu_valid;
    logic                  i_l2w_ready;
    logic [ADDR_WIDTH-1:0] o_lsu_pc;
    logic                  o_lsu_ctr_reg_wr_en;
    logic [ARGS_WIDTH-1:0] o_lsu_ctr_reg_wr_src;
    logic [GPRS_WIDTH-1:0] o_lsu_gpr_rd_id;
    logic [DATA_WIDTH-1:0] o_lsu_res;
    logic [DATA_WIDTH-1:0] o_lsu_mem_data;
    logic                  o_lsu_misalign;

    // lsu side
    modport slave (
        input  i_e2l_valid, i_e2l_pc, i_e2l_ctr_reg_wr_en, i_e2l_ctr_reg_wr_src,
               i_e2l_gpr_rd_id, i_e2l_ctr_ram_byt, i_e2l_ctr_ram_wr_en,
               i_e2l_res, i_e2l_rs2_data, i_ram_gnt, i_ram_rvalid, i_ram_rdata,
               i_l2w_ready,
        output o_lsu_ready, o_ram_req, o_ram_wr_en, o_ram_addr, o_ram_wstrb,
               o_ram_wdata, o_lsu_valid, o_lsu_pc, o_lsu_ctr_reg_wr_en,
               o_lsu_ctr_reg_wr_src, o_lsu_gpr_rd_id, o_lsu_res, o_lsu_mem_data,
               o_lsu_misalign
    );

    // execute / memory / writeback side
    modport master (
        output i_e2l_valid, i_e2l_pc, i_e2l_ctr_reg_wr_en, i_e2l_ctr_reg_wr_src,
               i_e2l_gpr_rd_id, i_e2l_ctr_ram_byt, i_e2l_ctr_ram_wr_en,
               i_e2l_res, i_e2l_rs2_data, i_ram_gnt, i_ram_rvalid, i_ram_rdata,
               i_l2w_ready,
        input  o_lsu_ready, o_ram_req, o_ram_wr_en, o_ram_addr, o_ram_wstrb,
               o_ram_wdata, o_lsu_valid, o_lsu_pc, o_lsu_ctr_reg_wr_en,
               o_lsu_ctr_reg_wr_src, o_lsu_gpr_rd_id, o_lsu_res, o_lsu_mem_data,
               o_lsu_misalign
    );
endinterface

// File: rtl/lsu.sv
// Load/store stage: one instruction in flight, memory access over req/gnt/rvalid,
// result handed to writeback over l2w valid/ready. Byte-lane logic assumes a 32-bit word.
module lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARGS_WIDTH = 4,
    parameter int GPRS_WIDTH = 5
) (
    input logic i_clk,
    input logic i_rst,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    state_t                state;
    logic [1:0]            off_q;
    logic [ARGS_WIDTH-1:0] byt_q;

    // decode of the instruction on the e2l bus, used only at capture
    logic [1:0]            in_off;
    logic                  in_store, in_load, in_sz1, in_sz2, in_mis;
    logic [3:0]            in_wstrb;
    logic [DATA_WIDTH-1:0] in_wdata;

    assign in_off   = bus.i_e2l_res[1:0];
    assign in_store = bus.i_e2l_ctr_ram_wr_en;
    assign in_load  = !in_store && (bus.i_e2l_ctr_reg_wr_src == `REG_WR_SRC_MEM);
    assign in_sz1   = (bus.i_e2l_ctr_ram_byt == `RAM_BYT_1_S) || (bus.i_e2l_ctr_ram_byt == `RAM_BYT_1_U);
    assign in_sz2   = (bus.i_e2l_ctr_ram_byt == `RAM_BYT_2_S) || (bus.i_e2l_ctr_ram_byt == `RAM_BYT_2_U);
    // alignment only matters when memory is actually touched
    assign in_mis   = (in_load || in_store) &&
                      ((in_sz2 && in_off == 2'd3) || (!in_sz1 && !in_sz2 && in_off != 2'd0));

    always_comb begin
        in_wstrb = 4'hF;
        in_wdata = bus.i_e2l_rs2_data;
        if (in_sz1) begin
            in_wstrb = 4'b0001 << in_off;
            in_wdata = {4{bus.i_e2l_rs2_data[7:0]}};
        end else if (in_sz2) begin
            in_wstrb = 4'b0011 << in_off;
            in_wdata = {2{bus.i_e2l_rs2_data[15:0]}};
        end
    end

    // load extraction: shift the addressed byte/half down to lane 0, then extend
    logic [DATA_WIDTH-1:0] rshift, ld_ext;
    assign rshift = bus.i_ram_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = rshift;
        case (byt_q)
            `RAM_BYT_1_S: ld_ext = {{24{rshift[7]}}, rshift[7:0]};
            `RAM_BYT_1_U: ld_ext = {24'h0, rshift[7:0]};
            `RAM_BYT_2_S: ld_ext = {{16{rshift[15]}}, rshift[15:0]};
            `RAM_BYT_2_U: ld_ext = {16'h0, rshift[15:0]};
            default:      ld_ext = rshift;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                    <= S_IDLE;
            off_q                    <= '0;
            byt_q                    <= '0;
            bus.o_lsu_ready          <= 1'b1;
            bus.o_lsu_valid          <= 1'b0;
            bus.o_ram_req            <= 1'b0;
            bus.o_ram_wr_en          <= 1'b0;
            bus.o_ram_addr           <= '0;
            bus.o_ram_wstrb          <= '0;
            bus.o_ram_wdata          <= '0;
            bus.o_lsu_pc             <= '0;
            bus.o_lsu_ctr_reg_wr_en  <= 1'b0;
            bus.o_lsu_ctr_reg_wr_src <= '0;
            bus.o_lsu_gpr_rd_id      <= '0;
            bus.o_lsu_res            <= '0;
            bus.o_lsu_mem_data       <= '0;
            bus.o_lsu_misalign       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.i_e2l_valid) begin
                    off_q                    <= in_off;
                    byt_q                    <= bus.i_e2l_ctr_ram_byt;
                    bus.o_lsu_ready          <= 1'b0;
                    bus.o_lsu_pc             <= bus.i_e2l_pc;
                    bus.o_lsu_ctr_reg_wr_en  <= bus.i_e2l_ctr_reg_wr_en && !in_mis;
                    bus.o_lsu_ctr_reg_wr_src <= bus.i_e2l_ctr_reg_wr_src;
                    bus.o_lsu_gpr_rd_id      <= bus.i_e2l_gpr_rd_id;
                    bus.o_lsu_res            <= bus.i_e2l_res;
                    bus.o_lsu_mem_data       <= '0;
                    bus.o_lsu_misalign       <= in_mis;
                    if (in_mis || !(in_load || in_store)) begin
                        bus.o_lsu_valid <= 1'b1;
                        state           <= S_OUT;
                    end else begin
                        bus.o_ram_req   <= 1'b1;
                        bus.o_ram_wr_en <= in_store;
                        bus.o_ram_addr  <= {bus.i_e2l_res[ADDR_WIDTH-1:2], 2'b00};
                        bus.o_ram_wstrb <= in_store ? in_wstrb : 4'h0;
                        bus.o_ram_wdata <= in_store ? in_wdata : '0;
                        state           <= S_REQ;
                    end
                end
                S_REQ: if (bus.i_ram_gnt) begin
                    bus.o_ram_req   <= 1'b0;
                    bus.o_ram_wr_en <= 1'b0;
                    bus.o_ram_wstrb <= 4'h0;
                    if (bus.o_ram_wr_en) begin
                        bus.o_lsu_valid <= 1'b1;
                        state           <= S_OUT;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: if (bus.i_ram_rvalid) begin
                    bus.o_lsu_mem_data <= ld_ext;
                    bus.o_lsu_valid    <= 1'b1;
                    state              <= S_OUT;
                end
                S_OUT: if (bus.i_l2w_ready) begin
                    bus.o_lsu_valid    <= 1'b0;
                    bus.o_lsu_misalign <= 1'b0;
                    bus.o_lsu_ready    <= 1'b1;
                    state              <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: inputs change and outputs are checked on the falling edge.
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S 4'd0
`endif
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U 4'd1
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S 4'd2
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U 4'd3
`endif
`ifndef RAM_BYT_4_U
`define RAM_BYT_4_U 4'd4
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 4'd1
`endif

module tb_lsu;
    logic i_clk = 1'b0;
    logic i_rst;
    int   total = 0;
    int   bad   = 0;

    lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARGS_WIDTH(4), .GPRS_WIDTH(5)) bus ();

    lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARGS_WIDTH(4), .GPRS_WIDTH(5)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] res, input logic [31:0] rs2, input logic [3:0] byt,
                        input logic st, input logic [3:0] src, input logic wen, input logic [4:0] rd);
        bus.i_e2l_valid          = 1'b1;
        bus.i_e2l_pc             = 32'h100 + res;
        bus.i_e2l_res            = res;
        bus.i_e2l_rs2_data       = rs2;
        bus.i_e2l_ctr_ram_byt    = byt;
        bus.i_e2l_ctr_ram_wr_en  = st;
        bus.i_e2l_ctr_reg_wr_src = src;
        bus.i_e2l_ctr_reg_wr_en  = wen;
        bus.i_e2l_gpr_rd_id      = rd;
        step();
        bus.i_e2l_valid = 1'b0;
    endtask

    initial begin
        i_rst                    = 1'b1;
        bus.i_e2l_valid          = 1'b0;
        bus.i_e2l_pc             = '0;
        bus.i_e2l_ctr_reg_wr_en  = 1'b0;
        bus.i_e2l_ctr_reg_wr_src = '0;
        bus.i_e2l_gpr_rd_id      = '0;
        bus.i_e2l_ctr_ram_byt    = '0;
        bus.i_e2l_ctr_ram_wr_en  = 1'b0;
        bus.i_e2l_res            = '0;
        bus.i_e2l_rs2_data       = '0;
        bus.i_ram_gnt            = 1'b0;
        bus.i_ram_rvalid         = 1'b0;
        bus.i_ram_rdata          = '0;
        bus.i_l2w_ready          = 1'b1;
        step();
        step();
        i_rst = 1'b0;

        // reset state
        chk("rst_ready",    bus.o_lsu_ready, 1);
        chk("rst_valid",    bus.o_lsu_valid, 0);
        chk("rst_req",      bus.o_ram_req, 0);
        chk("rst_wstrb",    bus.o_ram_wstrb, 0);
        chk("rst_res",      bus.o_lsu_res, 0);
        chk("rst_misalign", bus.o_lsu_misalign, 0);

        // ALU pass-through: valid one cycle after capture
        send(32'h1234, 32'h0, `RAM_BYT_4_U, 1'b0, 4'd0, 1'b1, 5'd5);
        chk("alu_valid",  bus.o_lsu_valid, 1);
        chk("alu_res",    bus.o_lsu_res, 32'h1234);
        chk("alu_pc",     bus.o_lsu_pc, 32'h1334);
        chk("alu_rd",     bus.o_lsu_gpr_rd_id, 5);
        chk("alu_wen",    bus.o_lsu_ctr_reg_wr_en, 1);
        chk("alu_mem",    bus.o_lsu_mem_data, 0);
        chk("alu_noreq",  bus.o_ram_req, 0);
        chk("alu_ready",  bus.o_lsu_ready, 0);
        step();
        chk("alu_drop",   bus.o_lsu_valid, 0);
        chk("alu_idle",   bus.o_lsu_ready, 1);

        // store byte at offset 3, grant held off for 3 cycles
        send(32'h1003, 32'hAABBCCDD, `RAM_BYT_1_U, 1'b1, 4'd0, 1'b0, 5'd0);
        chk("sb_req",   bus.o_ram_req, 1);
        chk("sb_we",    bus.o_ram_wr_en, 1);
        chk("sb_addr",  bus.o_ram_addr, 32'h1000);
        chk("sb_wstrb", bus.o_ram_wstrb, 4'b1000);
        chk("sb_wdata", bus.o_ram_wdata, 32'hDDDDDDDD);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sb_hold_req",  bus.o_ram_req, 1);
            chk("sb_hold_addr", bus.o_ram_addr, 32'h1000);
            chk("sb_hold_vld",  bus.o_lsu_valid, 0);
        end
        bus.i_ram_gnt = 1'b1;
        step();
        bus.i_ram_gnt = 1'b0;
        chk("sb_valid",  bus.o_lsu_valid, 1);
        chk("sb_reqoff", bus.o_ram_req, 0);
        chk("sb_mem",    bus.o_lsu_mem_data, 0);
        step();

        // store half at offset 2 with immediate grant: valid at N+2
        bus.i_ram_gnt = 1'b1;
        send(32'h1002, 32'h11223344, `RAM_BYT_2_U, 1'b1, 4'd0, 1'b0, 5'd0);
        chk("sh_wstrb", bus.o_ram_wstrb, 4'b1100);
        chk("sh_wdata", bus.o_ram_wdata, 32'h33443344);
        chk("sh_n1vld", bus.o_lsu_valid, 0);
        step();
        chk("sh_n2vld", bus.o_lsu_valid, 1);
        step();

        // store word; also treated as store when src says memory
        send(32'h1004, 32'hCAFEF00D, `RAM_BYT_4_U, 1'b1, `REG_WR_SRC_MEM, 1'b0, 5'd0);
        chk("sw_we",    bus.o_ram_wr_en, 1);
        chk("sw_wstrb", bus.o_ram_wstrb, 4'hF);
        chk("sw_wdata", bus.o_ram_wdata, 32'hCAFEF00D);
        step();
        chk("sw_valid", bus.o_lsu_valid, 1);
        step();

        // signed byte load at 0x2001: valid at N+3
        send(32'h2001, 32'h0, `RAM_BYT_1_S, 1'b0, `REG_WR_SRC_MEM, 1'b1, 5'd7);
        chk("lb_req",   bus.o_ram_req, 1);
        chk("lb_we",    bus.o_ram_wr_en, 0);
        chk("lb_wstrb", bus.o_ram_wstrb, 0);
        chk("lb_addr",  bus.o_ram_addr, 32'h2000);
        step();
        chk("lb_wait",  bus.o_lsu_valid, 0);
        chk("lb_reqoff", bus.o_ram_req, 0);
        bus.i_ram_rvalid = 1'b1;
        bus.i_ram_rdata  = 32'h00008000;
        step();
        bus.i_ram_rvalid = 1'b0;
        chk("lb_valid", bus.o_lsu_valid, 1);
        chk("lb_data",  bus.o_lsu_mem_data, 32'hFFFFFF80);
        chk("lb_rd",    bus.o_lsu_gpr_rd_id, 7);
        chk("lb_wen",   bus.o_lsu_ctr_reg_wr_en, 1);
        step();

        // unsigned half load at 0x2002
        send(32'h2002, 32'h0, `RAM_BYT_2_U, 1'b0, `REG_WR_SRC_MEM, 1'b1, 5'd8);
        step();
        bus.i_ram_rvalid = 1'b1;
        bus.i_ram_rdata  = 32'hBEEF0000;
        step();
        bus.i_ram_rvalid = 1'b0;
        chk("lhu_data", bus.o_lsu_mem_data, 32'h0000BEEF);
        step();

        // signed half load at offset 0, negative value
        send(32'h2000, 32'h0, `RAM_BYT_2_S, 1'b0, `REG_WR_SRC_MEM, 1'b1, 5'd9);
        step();
        bus.i_ram_rvalid = 1'b1;
        bus.i_ram_rdata  = 32'h1234F00F;
        step();
        bus.i_ram_rvalid = 1'b0;
        chk("lh_data", bus.o_lsu_mem_data, 32'hFFFFF00F);
        step();

        // misaligned word load, then backpressure with a new e2l request pending
        bus.i_l2w_ready = 1'b0;
        send(32'h3002, 32'h0, `RAM_BYT_4_U, 1'b0, `REG_WR_SRC_MEM, 1'b1, 5'd3);
        chk("mis_valid", bus.o_lsu_valid, 1);
        chk("mis_flag",  bus.o_lsu_misalign, 1);
        chk("mis_wen",   bus.o_lsu_ctr_reg_wr_en, 0);
        chk("mis_noreq", bus.o_ram_req, 0);
        chk("mis_mem",   bus.o_lsu_mem_data, 0);
        bus.i_e2l_valid = 1'b1;
        bus.i_e2l_res   = 32'h9999;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", bus.o_lsu_valid, 1);
            chk("bp_ready", bus.o_lsu_ready, 0);
            chk("bp_res",   bus.o_lsu_res, 32'h3002);
            chk("bp_mis",   bus.o_lsu_misalign, 1);
            chk("bp_noreq", bus.o_ram_req, 0);
        end
        bus.i_e2l_valid = 1'b0;
        bus.i_l2w_ready = 1'b1;
        step();
        chk("bp_drop",   bus.o_lsu_valid, 0);
        chk("bp_misclr", bus.o_lsu_misalign, 0);
        chk("bp_idle",   bus.o_lsu_ready, 1);

        // reset while waiting for read data; late rvalid must be ignored
        send(32'h2000, 32'h0, `RAM_BYT_4_U, 1'b0, `REG_WR_SRC_MEM, 1'b1, 5'd4);
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        bus.i_ram_rvalid = 1'b1;
        bus.i_ram_rdata  = 32'h12345678;
        step();
        bus.i_ram_rvalid = 1'b0;
        chk("rw_ready", bus.o_lsu_ready, 1);
        chk("rw_valid", bus.o_lsu_valid, 0);
        chk("rw_mem",   bus.o_lsu_mem_data, 0);
        chk("rw_req",   bus.o_ram_req, 0);
        step();
        chk("rw_valid2", bus.o_lsu_valid, 0);
        bus.i_ram_gnt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
